// File: rtl/sfq_stream_pkg.sv
// -----------------------------------------------------------------------------
// sfq_stream_pkg
// Shared constants and types for the SFQ pulse framer.
//   DEF_*        default values for the framer parameters
//   MAX_CNT_W    widest per-frame count the record type can carry
//   frame_rec_t  per-frame record {count, viol, sat} as buffered in the FIFO
//   ctr_width()  bit width for a counter/pointer covering n states (min 1)
// -----------------------------------------------------------------------------
package sfq_stream_pkg;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_WINDOW     = 16;
  localparam int DEF_MIN_GAP    = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  // The record carries a fixed-width count so one type serves every CNT_W
  // up to this limit; unused upper bits stay zero and are trimmed in synthesis.
  localparam int MAX_CNT_W = 16;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] count;
    logic                 viol;
    logic                 sat;
  } frame_rec_t;

  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfq_pulse_framer_if.sv
// -----------------------------------------------------------------------------
// sfq_pulse_framer_if
// Ready/valid stream of per-frame records leaving the framer.
//   out_valid  record available (framer -> consumer)
//   out_ready  consumer accepts record (consumer -> framer)
//   out_count  pulses counted in the frame (CNT_W bits)
//   out_viol   frame saw a spacing violation or unknown input
//   out_sat    frame count saturated
// Modports: master = framer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface sfq_pulse_framer_if
  import sfq_stream_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_viol;
  logic             out_sat;

  modport master (
    output out_valid,
    output out_count,
    output out_viol,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_viol,
    input  out_sat,
    output out_ready
  );

endinterface

// File: rtl/sfq_frame_fifo.sv
// -----------------------------------------------------------------------------
// sfq_frame_fifo
// Synchronous FIFO of frame records.
//   clk, rst_n  clock and asynchronous active-low reset (empties the FIFO)
//   push        write push_rec this cycle
//   push_rec    record to write
//   pop         consumer takes the head this cycle (ignored when empty)
//   head_rec    oldest stored record
//   empty/full  occupancy flags
//   push_drop   push refused because full with no same-cycle pop
// A pop and a push in the same cycle on a full FIFO both succeed.
// DEPTH must be a power of 2, at least 2.
// -----------------------------------------------------------------------------
module sfq_frame_fifo
  import sfq_stream_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  frame_rec_t push_rec,
  input  logic       pop,
  output frame_rec_t head_rec,
  output logic       empty,
  output logic       full,
  output logic       push_drop
);

  localparam int AW = ctr_width(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  frame_rec_t  mem_q [DEPTH];
  frame_rec_t  mem_d [DEPTH];
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_rec = mem_q[rd_ptr_q[AW-1:0]];

  // Pop is resolved first, so a full FIFO that is also being read this
  // cycle still has room for the incoming record.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    push_drop = push && !do_push;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_rec;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Storage and pointers; reset discards all buffered records.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sfq_pulse_framer.sv
// -----------------------------------------------------------------------------
// sfq_pulse_framer
// Samples a toggle-encoded SFQ line (every edge is one pulse), counts pulses
// per WINDOW-cycle frame, flags pulses closer than MIN_GAP cycles, and queues
// one {count, viol, sat} record per completed frame in a small FIFO.
//   clk, rst_n  clock and asynchronous active-low reset
//   sfq_in      toggle-encoded SFQ line (asynchronous to clk)
//   enable      framing enable; dropping it aborts the current frame
//   rec_if      record stream (master modport: valid/count/viol/sat, ready)
//   overflow    one-cycle pulse when a frame record is dropped (FIFO full)
//   x_err       sticky flag: unknown value seen on the synchronized line
// Optional feature macro: SFQ_XCHECK_EN enables X/Z detection on the
// synchronized input; without it x_err stays 0 and only the synthesizable
// path is built.
// -----------------------------------------------------------------------------
module sfq_pulse_framer
  import sfq_stream_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int MIN_GAP    = DEF_MIN_GAP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sfq_in,
  input  logic               enable,
  sfq_pulse_framer_if.master rec_if,
  output logic               overflow,
  output logic               x_err
);

  localparam int WIN_W = ctr_width(WINDOW);
  localparam int GAP_W = ctr_width(MIN_GAP + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             viol_q, viol_d;
  logic             sat_q, sat_d;
  logic             overflow_q, overflow_d;
  logic             x_err_q, x_err_d;

  logic             s2_unknown;
  logic             pulse_det;
  logic             gap_short;
  logic [CNT_W-1:0] count_inc;
  logic             viol_inc;
  logic             sat_inc;
  logic             push;
  frame_rec_t       push_rec;
  frame_rec_t       head_rec;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_drop;

`ifdef SFQ_XCHECK_EN
  assign s2_unknown = $isunknown(s2_q);
`else
  assign s2_unknown = 1'b0;
`endif

  // Synchronizer, edge detect, spacing tracking and frame accumulation.
  // An unknown synchronized sample counts as "no edge" and leaves prev
  // untouched so the line recovers without a phantom pulse. The gap counter
  // reads 1 in the cycle after a pulse and saturates at MIN_GAP, so a pulse
  // seen while it is still below MIN_GAP arrived too soon. The accumulated
  // values including this cycle's pulse (count_inc etc.) feed both the
  // running frame and, on the last window cycle, the closing record.
  always_comb begin
    s1_d      = sfq_in;
    s2_d      = s1_q;
    prev_d    = s2_unknown ? prev_q : s2_q;
    pulse_det = !s2_unknown && (s2_q != prev_q);
    gap_short = (gap_q < GAP_MAX);

    gap_d = gap_q;
    if (pulse_det) begin
      gap_d = GAP_ONE;
    end else if (gap_short) begin
      gap_d = gap_q + GAP_ONE;
    end

    count_inc = count_q;
    sat_inc   = sat_q;
    viol_inc  = viol_q || s2_unknown || (pulse_det && gap_short);
    if (pulse_det) begin
      if (count_q == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        count_inc = count_q + CNT_ONE;
      end
    end

    push_rec       = '0;
    push_rec.count = MAX_CNT_W'(count_inc);
    push_rec.viol  = viol_inc;
    push_rec.sat   = sat_inc;

    push    = 1'b0;
    win_d   = '0;
    count_d = '0;
    viol_d  = 1'b0;
    sat_d   = 1'b0;
    if (enable) begin
      if (win_q == WIN_LAST) begin
        push = 1'b1;
      end else begin
        win_d   = win_q + WIN_ONE;
        count_d = count_inc;
        viol_d  = viol_inc;
        sat_d   = sat_inc;
      end
    end

    overflow_d = push_drop;
    x_err_d    = x_err_q || s2_unknown;
  end

  // State registers. The gap counter resets to MIN_GAP so the first pulse
  // after reset is never treated as too close to an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      gap_q      <= GAP_MAX;
      win_q      <= '0;
      count_q    <= '0;
      viol_q     <= 1'b0;
      sat_q      <= 1'b0;
      overflow_q <= 1'b0;
      x_err_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      gap_q      <= gap_d;
      win_q      <= win_d;
      count_q    <= count_d;
      viol_q     <= viol_d;
      sat_q      <= sat_d;
      overflow_q <= overflow_d;
      x_err_q    <= x_err_d;
    end
  end

  sfq_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rec  (push_rec),
    .pop       (rec_if.out_ready),
    .head_rec  (head_rec),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_drop (push_drop)
  );

  // Record fields are forced to zero while nothing is queued.
  assign rec_if.out_valid = !fifo_empty;
  assign rec_if.out_count = fifo_empty ? '0 : head_rec.count[CNT_W-1:0];
  assign rec_if.out_viol  = !fifo_empty && head_rec.viol;
  assign rec_if.out_sat   = !fifo_empty && head_rec.sat;
  assign overflow         = overflow_q;
  assign x_err            = x_err_q;

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_sfq_pulse_framer.sv
// -----------------------------------------------------------------------------
// tb_sfq_pulse_framer
// Self-checking bench for sfq_pulse_framer (CNT_W=3 so saturation is
// reachable in one 16-cycle frame). A frame-level reference model tracks
// pulses, spacing, frames and the record queue; a compare process checks the
// DUT against it every cycle, and directed frames check literal records.
// The X-input scenario is only built when SFQ_XCHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_sfq_pulse_framer;
  import sfq_stream_pkg::*;

  localparam int CNT_W   = 3;
  localparam int WINDOW  = 16;
  localparam int MIN_GAP = 2;
  localparam int DEPTH   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic sfq_in;
  logic enable;
  logic overflow;
  logic x_err;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic check_live = 1'b1;

  sfq_pulse_framer_if #(.CNT_W(CNT_W)) rec_if ();

  sfq_pulse_framer #(
    .CNT_W      (CNT_W),
    .WINDOW     (WINDOW),
    .MIN_GAP    (MIN_GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sfq_in   (sfq_in),
    .enable   (enable),
    .rec_if   (rec_if),
    .overflow (overflow),
    .x_err    (x_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports a failure with actual and required.
  function automatic void checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a toggle on the line becomes a pulse two samples later;
  // frames are WINDOW consecutive enabled cycles; records queue up to DEPTH.
  typedef struct {
    int count;
    bit viol;
    bit sat;
  } exp_rec_t;

  exp_rec_t exp_q[$];
  bit       line_hist[$] = '{1'b0, 1'b0, 1'b0};
  int       cyc = 0;
  int       last_pulse = -1000;
  int       f_pos = 0;
  int       f_pulses = 0;
  bit       f_viol = 1'b0;
  bit       exp_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin : ref_model
    bit       pulse;
    bit       too_close;
    exp_rec_t r;
    if (!rst_n) begin
      exp_q.delete();
      line_hist  = '{1'b0, 1'b0, 1'b0};
      cyc        = 0;
      last_pulse = -1000;
      f_pos      = 0;
      f_pulses   = 0;
      f_viol     = 1'b0;
      exp_ovf    = 1'b0;
    end else begin
      cyc++;
      pulse     = (line_hist[1] != line_hist[0]);
      too_close = pulse && ((cyc - last_pulse) < MIN_GAP);
      if (pulse) last_pulse = cyc;
      exp_ovf = 1'b0;
      if ((exp_q.size() > 0) && (rec_if.out_ready === 1'b1)) void'(exp_q.pop_front());
      if (enable) begin
        if (pulse) begin
          f_pulses++;
          f_viol = f_viol | too_close;
        end
        if (f_pos == WINDOW - 1) begin
          r.count = (f_pulses > CNT_MAX) ? CNT_MAX : f_pulses;
          r.sat   = (f_pulses > CNT_MAX);
          r.viol  = f_viol;
          if (exp_q.size() < DEPTH) exp_q.push_back(r);
          else exp_ovf = 1'b1;
          f_pos    = 0;
          f_pulses = 0;
          f_viol   = 1'b0;
        end else begin
          f_pos++;
        end
      end else begin
        f_pos    = 0;
        f_pulses = 0;
        f_viol   = 1'b0;
      end
      line_hist.push_back(sfq_in);
      void'(line_hist.pop_front());
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin : compare
    if (check_live) begin
      checkOutput("model_valid", int'(rec_if.out_valid), (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) begin
        checkOutput("model_count", int'(rec_if.out_count), exp_q[0].count);
        checkOutput("model_viol", int'(rec_if.out_viol), int'(exp_q[0].viol));
        checkOutput("model_sat", int'(rec_if.out_sat), int'(exp_q[0].sat));
      end
      checkOutput("model_overflow", int'(overflow), int'(exp_ovf));
      checkOutput("model_x_err", int'(x_err), 0);
    end
  end

  // Drives one frame's worth of cycles starting at a falling edge; bit i of
  // tog toggles the line and bit i of en sets enable for frame cycle i.
  task automatic applyStimulus(input logic [15:0] tog, input logic [15:0] en);
    for (int i = 0; i < WINDOW; i++) begin
      enable = en[i];
      if (tog[i]) sfq_in = ~sfq_in;
      @(negedge clk);
    end
  endtask

  task automatic checkRecord(input string tag, input int cnt, input int v, input int s);
    checkOutput({tag, "_valid"}, int'(rec_if.out_valid), 1);
    checkOutput({tag, "_count"}, int'(rec_if.out_count), cnt);
    checkOutput({tag, "_viol"}, int'(rec_if.out_viol), v);
    checkOutput({tag, "_sat"}, int'(rec_if.out_sat), s);
  endtask

  initial begin
    rst_n            = 1'b0;
    sfq_in           = 1'b0;
    enable           = 1'b0;
    rec_if.out_ready = 1'b0;

    // Reset held while the line toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sfq_in = ~sfq_in;
      checkOutput("reset_valid", int'(rec_if.out_valid), 0);
      checkOutput("reset_overflow", int'(overflow), 0);
      checkOutput("reset_x_err", int'(x_err), 0);
    end
    @(negedge clk);
    rst_n            = 1'b1;
    rec_if.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_valid", int'(rec_if.out_valid), 0);
    end

    // Back-to-back frames with enable held high.
    applyStimulus(16'h0111, 16'hFFFF);
    checkRecord("normal", 3, 0, 0);
    applyStimulus(16'h000C, 16'hFFFF);
    checkRecord("spacing", 2, 1, 0);
    applyStimulus(16'h4000, 16'hFFFF);
    checkRecord("presat", 0, 0, 0);
    applyStimulus(16'h1555, 16'hFFFF);
    checkRecord("saturate", 7, 0, 1);
    checkOutput("model_pin_sat_count", exp_q[0].count, 7);
    checkOutput("model_pin_sat_flag", int'(exp_q[0].sat), 1);

    // Backpressure: six frames with one pulse each, consumer stalled.
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rec_if.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(16'h0020, 16'hFFFF);
      checkOutput("bp_overflow", int'(overflow), (k >= 5) ? 1 : 0);
      checkOutput("bp_valid", int'(rec_if.out_valid), 1);
      checkOutput("bp_head_count", int'(rec_if.out_count), 1);
    end
    checkOutput("model_pin_bp_depth", exp_q.size(), 4);
    enable           = 1'b0;
    rec_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_valid", int'(rec_if.out_valid), 1);
      checkOutput("drain_count", int'(rec_if.out_count), 1);
      @(negedge clk);
    end
    checkOutput("drain_empty", int'(rec_if.out_valid), 0);

    // Abort: enable drops at window position 7.
    applyStimulus(16'h0002, 16'h007F);
    checkOutput("abort_valid", int'(rec_if.out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("abort_idle_valid", int'(rec_if.out_valid), 0);
    end
    applyStimulus(16'h0000, 16'hFFFF);
    checkRecord("reenable", 0, 0, 0);

    // Reset in the middle of operation with records queued.
    rec_if.out_ready = 1'b0;
    applyStimulus(16'h0010, 16'hFFFF);
    applyStimulus(16'h0010, 16'hFFFF);
    checkOutput("prereset_valid", int'(rec_if.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", int'(rec_if.out_valid), 0);
    checkOutput("midreset_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n            = 1'b1;
    enable           = 1'b0;
    rec_if.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("postreset_valid", int'(rec_if.out_valid), 0);

`ifdef SFQ_XCHECK_EN
    // Unknown line value for one cycle inside an enabled frame.
    check_live = 1'b0;
    sfq_in     = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      enable = 1'b1;
      sfq_in = (i == 3) ? 1'bx : 1'b0;
      @(negedge clk);
    end
    checkOutput("xcheck_x_err", int'(x_err), 1);
    checkOutput("xcheck_valid", int'(rec_if.out_valid), 1);
    checkOutput("xcheck_viol", int'(rec_if.out_viol), 1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checkOutput("xcheck_sticky", int'(x_err), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    check_live = 1'b1;
`endif

    // Randomized traffic: first half mostly ready, second half mostly stalled.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) sfq_in = ~sfq_in;
      enable = ($urandom_range(0, 39) != 0);
      rec_if.out_ready = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end

    enable           = 1'b0;
    rec_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
